uart_rx_frame_ctrl: RTL and testbench
=====================================

Name: uart_rx_frame_ctrl

Overview:
- Sequences the byte stream coming out of UART_reciever (byte_out / ready_out) into framed packets.
- Frame format, one UART byte each: SYNC, LEN, LEN payload bytes, CHK.
- Forwards payload bytes downstream as they arrive. Ends each frame with either a frame_done or a frame_err pulse.
- Aborts stalled frames with an inter-byte timeout. Sits between the UART receiver and the packet consumer.

Parameters:
- SYNC_BYTE, 8'hA5: frame start marker.
- MAX_LEN, 16: largest legal LEN value (1..255).
- TIMEOUT, 200: clocks allowed between consecutive bytes inside a frame.
- cnt_width, 8: width of the timeout counter; must satisfy 2**cnt_width > TIMEOUT.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high; clears all state and outputs.
- byte_in  in  8  received byte; connect to UART_reciever byte_out.
- byte_valid  in  1  one-cycle strobe, byte_in valid; connect to ready_out.
- out_byte  out  8  forwarded payload byte.
- out_valid  out  1  one-cycle strobe, out_byte valid.
- frame_done  out  1  one-cycle pulse: frame complete, checksum good.
- frame_err  out  1  one-cycle pulse: frame aborted or checksum bad.
- busy  out  1  high while not in IDLE.

Behaviour:
- Reset values: state IDLE; out_byte 0, out_valid 0, frame_done 0, frame_err 0, busy 0; len/remaining count 0, checksum accumulator 0, timeout counter 0.
- All outputs are registered. Every response appears exactly 1 clock after the byte_valid cycle (or timeout cycle) that caused it.
- State machine IDLE -> LEN -> PAYLOAD -> CHECK -> IDLE. Transitions happen only on byte_valid, or on timeout as described below.
- IDLE:
  - byte_valid with byte_in==SYNC_BYTE -> LEN.
  - Any other byte is ignored; no output.
- LEN:
  - byte_in==0 -> CHECK with sum=0.
  - byte_in>MAX_LEN -> frame_err pulse, IDLE.
  - Otherwise: store remaining=byte_in, sum=byte_in, go to PAYLOAD.
- PAYLOAD, on each byte:
  - out_byte=byte_in and out_valid=1 on the next cycle.
  - sum=sum+byte_in, mod 256 (8-bit wrap, carry discarded); remaining decrements.
  - When the byte that brings remaining to 0 arrives -> CHECK.
  - A byte equal to SYNC_BYTE inside the payload is data, not a resync.
- CHECK:
  - byte_in==sum -> frame_done pulse.
  - Otherwise -> frame_err pulse.
  - Either way, return to IDLE.
- Timeout:
  - The counter runs only in LEN, PAYLOAD and CHECK. It clears on every byte_valid and on entering IDLE.
  - When the counter reaches TIMEOUT-1 with no byte_valid -> frame_err pulse next cycle, IDLE.
  - IDLE never times out.
- Simultaneous events: byte_valid in the same cycle the counter hits TIMEOUT-1 -> the byte wins; it is processed normally and the counter clears. No error is raised.
- frame_done and frame_err are never high together. out_valid is never high in the same cycle as frame_done or frame_err.
- Payload bytes of a frame that later errors have already been forwarded. The consumer discards them on frame_err.
- busy=1 from the cycle after SYNC is accepted until the cycle frame_done or frame_err is asserted; busy=0 in that cycle.
- Reset asserted mid-frame: immediate return to IDLE, all outputs 0, no error pulse. Bytes after reset release need a fresh SYNC.
- byte_valid is assumed at most every other clock. Back-to-back strobes must still be handled: one byte per strobe, no drops.

Test Plan:
- Good frame: bytes A5 03 10 20 30 63 -> out_valid ×3 with out_byte 10, 20, 30; then frame_done ×1, frame_err stays 0; busy falls with frame_done.
- Bad checksum: A5 02 FF 02 00 -> out_bytes FF, 02 (sum 02+FF+02 = 0x103 -> 0x03 ≠ 00) -> frame_err ×1, no frame_done.
- Framing: noise bytes 00 55 FF before A5 01 A5 A6 -> noise produces no output; payload A5 forwarded as data; CHK A6 accepted -> frame_done.
- Length edges: A5 00 00 -> frame_done with no out_valid. A5 11 (17 > MAX_LEN 16) -> frame_err 1 clock after LEN, back in IDLE.
- Timeout: A5 02 10, then silence -> frame_err exactly TIMEOUT clocks after the 10 strobe. Repeat with the 20 strobe landing on cycle TIMEOUT-1 -> no error, frame continues.
- Reset mid-PAYLOAD: A5 04 01, assert reset -> all outputs 0, no frame_err; then A5 01 07 08 -> frame_done.

Source files
------------

// File: rtl/uart_rx_frame_ctrl.sv
// Frames the UART receiver byte stream (SYNC, LEN, payload, CHK), forwards payload bytes,
// and ends each frame with a registered frame_done or frame_err pulse; inter-byte timeout aborts stalls.
module uart_rx_frame_ctrl #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         MAX_LEN   = 16,
  parameter int         TIMEOUT   = 200,
  parameter int         cnt_width = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic [7:0] out_byte,
  output logic       out_valid,
  output logic       frame_done,
  output logic       frame_err,
  output logic       busy
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_LEN     = 2'd1;
  localparam logic [1:0] ST_PAYLOAD = 2'd2;
  localparam logic [1:0] ST_CHECK   = 2'd3;

  localparam logic [7:0]           MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [cnt_width-1:0] TO_LAST   = cnt_width'(TIMEOUT - 1);
  localparam logic [cnt_width-1:0] CNT_ONE   = cnt_width'(1);

  logic [1:0]           state_q, state_d;
  logic [7:0]           rem_q, rem_d;
  logic [7:0]           sum_q, sum_d;
  logic [cnt_width-1:0] cnt_q, cnt_d;
  logic [7:0]           out_byte_q, out_byte_d;
  logic                 out_valid_q, out_valid_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic                 busy_q, busy_d;

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    sum_d       = sum_q;
    cnt_d       = cnt_q;
    out_byte_d  = out_byte_q;
    out_valid_d = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;

    if (state_q != ST_IDLE) begin
      cnt_d = cnt_q + CNT_ONE;
    end

    case (state_q)
      ST_IDLE: begin
        if (byte_valid && byte_in == SYNC_BYTE) begin
          state_d = ST_LEN;
        end
      end
      ST_LEN: begin
        if (byte_valid) begin
          if (byte_in == 8'd0) begin
            rem_d   = 8'd0;
            sum_d   = 8'd0;
            state_d = ST_CHECK;
          end else if (byte_in > MAX_LEN_B) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            rem_d   = byte_in;
            sum_d   = byte_in;
            state_d = ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        if (byte_valid) begin
          out_byte_d  = byte_in;
          out_valid_d = 1'b1;
          sum_d       = sum_q + byte_in;
          rem_d       = rem_q - 8'd1;
          if (rem_q == 8'd1) begin
            state_d = ST_CHECK;
          end
        end
      end
      default: begin
        if (byte_valid) begin
          done_d  = (byte_in == sum_q);
          err_d   = (byte_in != sum_q);
          state_d = ST_IDLE;
        end
      end
    endcase

    // A byte arriving on the last allowed cycle wins over the timeout.
    if (state_q != ST_IDLE && !byte_valid && cnt_q == TO_LAST) begin
      err_d   = 1'b1;
      state_d = ST_IDLE;
    end

    if (byte_valid || state_d == ST_IDLE) begin
      cnt_d = '0;
    end
  end

  assign busy_d = (state_d != ST_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      rem_q       <= 8'd0;
      sum_q       <= 8'd0;
      cnt_q       <= '0;
      out_byte_q  <= 8'd0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      sum_q       <= sum_d;
      cnt_q       <= cnt_d;
      out_byte_q  <= out_byte_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
    end
  end

  assign out_byte   = out_byte_q;
  assign out_valid  = out_valid_q;
  assign frame_done = done_q;
  assign frame_err  = err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Bench for uart_rx_frame_ctrl: directed frames plus a random frame stream, checked every
// cycle against a frame-parsing reference model built on a byte queue.
module tb_uart_rx_frame_ctrl;

  localparam int         TIMEOUT = 200;
  localparam int         MAX_LEN = 16;
  localparam logic [7:0] SYNC    = 8'hA5;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic [7:0] out_byte;
  logic       out_valid;
  logic       frame_done;
  logic       frame_err;
  logic       busy;

  always #5 clk = ~clk;

  uart_rx_frame_ctrl #(
    .SYNC_BYTE(SYNC),
    .MAX_LEN  (MAX_LEN),
    .TIMEOUT  (TIMEOUT),
    .cnt_width(8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .byte_in   (byte_in),
    .byte_valid(byte_valid),
    .out_byte  (out_byte),
    .out_valid (out_valid),
    .frame_done(frame_done),
    .frame_err (frame_err),
    .busy      (busy)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int last_cyc = 0;
  int cnt_valid, cnt_done, cnt_err;

  logic [7:0] frame[$];
  logic [7:0] m_byte = 8'd0;
  logic       m_valid, m_done, m_err;
  logic [7:0] pkt[$];

  task automatic check1(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: the bytes of the frame in progress are kept in a queue; the decision for each
  // byte depends only on how many bytes the frame holds and the LEN byte it carries.
  task automatic model_edge(input logic v, input logic [7:0] b);
    int sum;
    m_valid = 1'b0;
    m_done  = 1'b0;
    m_err   = 1'b0;
    if (frame.size() == 0) begin
      if (v && b == SYNC) begin
        frame.push_back(b);
        last_cyc = cyc;
      end
    end else if (v) begin
      frame.push_back(b);
      last_cyc = cyc;
      if (frame.size() == 2) begin
        if (int'(b) > MAX_LEN) begin
          m_err = 1'b1;
          frame.delete();
        end
      end else if (frame.size() <= int'(frame[1]) + 2) begin
        m_valid = 1'b1;
        m_byte  = b;
      end else begin
        sum = 0;
        for (int i = 1; i < frame.size() - 1; i++) sum += int'(frame[i]);
        if ((sum % 256) == int'(b)) m_done = 1'b1;
        else m_err = 1'b1;
        frame.delete();
      end
    end else if (cyc - last_cyc == TIMEOUT) begin
      m_err = 1'b1;
      frame.delete();
    end
  endtask

  task automatic tick(input logic v, input logic [7:0] b);
    byte_valid = v;
    byte_in    = v ? b : 8'($urandom);
    @(posedge clk);
    cyc++;
    model_edge(v, b);
    #1;
    byte_valid = 1'b0;
    check1("out_valid",  {7'd0, out_valid},  {7'd0, m_valid});
    check1("frame_done", {7'd0, frame_done}, {7'd0, m_done});
    check1("frame_err",  {7'd0, frame_err},  {7'd0, m_err});
    check1("busy",       {7'd0, busy},       {7'd0, (frame.size() != 0)});
    check1("out_byte",   out_byte,           m_byte);
    cnt_valid += int'(out_valid);
    cnt_done  += int'(frame_done);
    cnt_err   += int'(frame_err);
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    repeat (gap) tick(1'b0, 8'd0);
    tick(1'b1, b);
  endtask

  task automatic send_pkt(input logic [7:0] p[$], input int gap);
    foreach (p[i]) send(p[i], gap);
  endtask

  task automatic clear_counts();
    cnt_valid = 0;
    cnt_done  = 0;
    cnt_err   = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    check1("rst_out_valid",  {7'd0, out_valid},  8'd0);
    check1("rst_frame_done", {7'd0, frame_done}, 8'd0);
    check1("rst_frame_err",  {7'd0, frame_err},  8'd0);
    check1("rst_busy",       {7'd0, busy},       8'd0);
    check1("rst_out_byte",   out_byte,           8'd0);
    frame.delete();
    m_byte = 8'd0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    int len;
    int sum;
    byte_valid = 1'b0;
    byte_in    = 8'd0;
    reset      = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    tick(1'b0, 8'd0);

    // Good frame.
    clear_counts();
    pkt = '{8'hA5, 8'h03, 8'h10, 8'h20, 8'h30, 8'h63};
    send_pkt(pkt, 1);
    tick(1'b0, 8'd0);
    check1("good_valid_cnt", 8'(cnt_valid), 8'd3);
    check1("good_done_cnt",  8'(cnt_done),  8'd1);
    check1("good_err_cnt",   8'(cnt_err),   8'd0);

    // Bad checksum.
    clear_counts();
    pkt = '{8'hA5, 8'h02, 8'hFF, 8'h02, 8'h00};
    send_pkt(pkt, 1);
    tick(1'b0, 8'd0);
    check1("badchk_valid_cnt", 8'(cnt_valid), 8'd2);
    check1("badchk_done_cnt",  8'(cnt_done),  8'd0);
    check1("badchk_err_cnt",   8'(cnt_err),   8'd1);

    // Noise before SYNC, SYNC value as payload data; back-to-back strobes.
    clear_counts();
    pkt = '{8'h00, 8'h55, 8'hFF, 8'hA5, 8'h01, 8'hA5, 8'hA6};
    send_pkt(pkt, 0);
    tick(1'b0, 8'd0);
    check1("sync_data_valid_cnt", 8'(cnt_valid), 8'd1);
    check1("sync_data_done_cnt",  8'(cnt_done),  8'd1);

    // Zero length and over-length.
    clear_counts();
    pkt = '{8'hA5, 8'h00, 8'h00};
    send_pkt(pkt, 1);
    tick(1'b0, 8'd0);
    check1("len0_valid_cnt", 8'(cnt_valid), 8'd0);
    check1("len0_done_cnt",  8'(cnt_done),  8'd1);
    clear_counts();
    send(8'hA5, 1);
    send(8'h11, 1);
    check1("len17_err_now", {7'd0, frame_err}, 8'd1);
    check1("len17_busy",    {7'd0, busy},      8'd0);

    // Timeout fires exactly TIMEOUT clocks after the last strobe.
    clear_counts();
    pkt = '{8'hA5, 8'h02, 8'h10};
    send_pkt(pkt, 1);
    repeat (TIMEOUT - 1) tick(1'b0, 8'd0);
    check1("to_no_err_early", 8'(cnt_err), 8'd0);
    tick(1'b0, 8'd0);
    check1("to_err_on_time", {7'd0, frame_err}, 8'd1);

    // Byte on the last allowed cycle beats the timeout.
    clear_counts();
    pkt = '{8'hA5, 8'h02, 8'h10};
    send_pkt(pkt, 1);
    send(8'h20, TIMEOUT - 1);
    check1("to_race_valid", {7'd0, out_valid}, 8'd1);
    send(8'h32, 1);
    check1("to_race_done", {7'd0, frame_done}, 8'd1);
    check1("to_race_err_cnt", 8'(cnt_err), 8'd0);

    // Reset mid-payload, then a fresh frame.
    clear_counts();
    pkt = '{8'hA5, 8'h04, 8'h01};
    send_pkt(pkt, 1);
    do_reset();
    tick(1'b0, 8'd0);
    check1("midrst_err_cnt", 8'(cnt_err), 8'd0);
    pkt = '{8'hA5, 8'h01, 8'h07, 8'h08};
    send_pkt(pkt, 1);
    check1("midrst_done", {7'd0, frame_done}, 8'd1);

    // Random stream: noise, random lengths (some illegal), corrupt checksums, varied gaps.
    for (int f = 0; f < 40; f++) begin
      repeat ($urandom_range(2)) send(8'($urandom_range(8'hA4)), $urandom_range(3));
      len = ($urandom_range(9) == 0) ? $urandom_range(MAX_LEN + 4, MAX_LEN + 1)
                                     : $urandom_range(MAX_LEN);
      send(SYNC, $urandom_range(3));
      send(8'(len), $urandom_range(3));
      if (len <= MAX_LEN) begin
        sum = len;
        for (int i = 0; i < len; i++) begin
          logic [7:0] d;
          d = 8'($urandom);
          sum += int'(d);
          send(d, ($urandom_range(19) == 0) ? $urandom_range(TIMEOUT, TIMEOUT - 2)
                                            : $urandom_range(3));
        end
        if ($urandom_range(3) == 0) sum += 1 + $urandom_range(254);
        send(8'(sum), $urandom_range(3));
      end
    end
    repeat (TIMEOUT + 2) tick(1'b0, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
